// File: rtl/pe_config_loader.sv
// Configuration loader for the PE array: assembles nibble-serial control words
// in a shadow buffer, commits them atomically and then drives the shared PE enable.
module pe_config_loader #(
    parameter int NUM_PE = 4,
    parameter int CW     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic [3:0]           cfg_data,
    output logic                 cfg_ready,
    input  logic                 step,
    output logic [NUM_PE*CW-1:0] ctrl_out,
    output logic                 pe_en,
    output logic                 loaded,
    output logic                 err
);

    localparam int NIBBLES = 2 * NUM_PE;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam int POS_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_PE*CW-1:0] shadow, shadow_d;
    logic [NUM_PE*CW-1:0] ctrl_d;
    logic                 pe_en_d, loaded_d, err_d;
    logic                 nib_accept;
    logic [POS_W-1:0]     nib_pos;

    assign cfg_ready  = (state == LOAD);
    assign nib_accept = cfg_valid && cfg_ready;
    // Nibble k lands in PE k/2; even k is the high nibble of that word.
    assign nib_pos    = {cnt[CNT_W-1:1], ~cnt[0], 2'b00};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state;
        cnt_d    = cnt;
        shadow_d = shadow;
        ctrl_d   = ctrl_out;
        pe_en_d  = 1'b0;
        loaded_d = loaded;
        err_d    = err;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart beats any nibble handshake in the same cycle.
                if (cfg_start) begin
                    cnt_d = '0;
                    err_d = 1'b1;
                end else if (nib_accept) begin
                    shadow_d[nib_pos +: 4] = cfg_data;
                    if (cnt == LAST) begin
                        ctrl_d   = shadow_d;
                        state_d  = COMMIT;
                        pe_en_d  = 1'b1;
                        loaded_d = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            COMMIT: state_d = RUN;
            RUN: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    loaded_d = 1'b0;
                end else begin
                    pe_en_d = step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: the shadow buffer is a plain register bank and is reset with the rest of the state.
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            ctrl_out <= '0;
            pe_en    <= 1'b0;
            loaded   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            shadow   <= shadow_d;
            ctrl_out <= ctrl_d;
            pe_en    <= pe_en_d;
            loaded   <= loaded_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed testbench for pe_config_loader (NUM_PE=4): frames, gaps, stepping,
// restarts, reload from RUN and mid-frame reset.
module tb_pe_config_loader;

    logic        clock = 1'b0;
    logic        reset, cfg_start, cfg_valid, step;
    logic [3:0]  cfg_data;
    logic        cfg_ready, pe_en, loaded, err;
    logic [31:0] ctrl_out;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] frame_a [8] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hF, 4'h0, 4'h1, 4'h2};
    logic [3:0] frame_b [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
    localparam logic [31:0] WORD_A = 32'h12F03CA5;
    localparam logic [31:0] WORD_B = 32'h44332211;

    pe_config_loader #(.NUM_PE(4), .CW(8)) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .step(step), .ctrl_out(ctrl_out),
        .pe_en(pe_en), .loaded(loaded), .err(err)
    );

    always #5 clock = ~clock;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 4'h7; step = 1'b1;
        reset = 1'b1;
        tick(); tick();
        vectors++;
        if ({cfg_ready, pe_en, loaded, err, ctrl_out} !== {4'b0000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset: rdy/en/ld/err=%b ctrl=%h, expected 0000 ctrl=00000000",
                     {cfg_ready, pe_en, loaded, err}, ctrl_out);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({cfg_ready, pe_en, loaded} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_ignores_valid_step: rdy/en/ld=%b expected 000", {cfg_ready, pe_en, loaded});
        end
        cfg_valid = 1'b0; step = 1'b0;
    endtask

    task automatic test_back_to_back();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        vectors++;
        if ({cfg_ready, ctrl_out} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_enter_load: rdy=%b ctrl=%h expected 1 00000000", cfg_ready, ctrl_out);
        end
        for (int k = 0; k < 8; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = frame_a[k];
            tick();
        end
        cfg_valid = 1'b0;
        vectors++;
        if ({ctrl_out, pe_en, loaded, err, cfg_ready} !== {WORD_A, 4'b1100}) begin
            miscompares++;
            $display("FAIL b2b_commit: ctrl=%h en/ld/err/rdy=%b expected %h 1100",
                     ctrl_out, {pe_en, loaded, err, cfg_ready}, WORD_A);
        end
        // step during COMMIT must not produce a pe_en cycle
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if ({ctrl_out, pe_en, loaded, err} !== {WORD_A, 3'b010}) begin
            miscompares++;
            $display("FAIL b2b_after_commit: ctrl=%h en/ld/err=%b expected %h 010",
                     ctrl_out, {pe_en, loaded, err}, WORD_A);
        end
    endtask

    task automatic test_step();
        logic [7:0] pattern;
        pattern = 8'b0010_0011;   // step high in relative cycles 0, 1 and 5
        for (int i = 0; i < 8; i++) begin
            step = pattern[i];
            tick();
            vectors++;
            if ({pe_en, loaded} !== {pattern[i], 1'b1}) begin
                miscompares++;
                $display("FAIL step_cycle%0d: en/ld=%b expected %b", i, {pe_en, loaded}, {pattern[i], 1'b1});
            end
        end
        step = 1'b0;
        tick();
        vectors++;
        if (pe_en !== 1'b0) begin
            miscompares++;
            $display("FAIL step_idle: pe_en=%b expected 0", pe_en);
        end
    endtask

    task automatic test_run_reload();
        cfg_start = 1'b1;
        step      = 1'b1;
        tick();
        cfg_start = 1'b0;
        vectors++;
        if ({cfg_ready, pe_en, loaded, ctrl_out} !== {3'b100, WORD_A}) begin
            miscompares++;
            $display("FAIL reload_enter: rdy/en/ld=%b ctrl=%h expected 100 %h",
                     {cfg_ready, pe_en, loaded}, ctrl_out, WORD_A);
        end
        for (int k = 0; k < 7; k++) begin
            send_nib(frame_b[k]);
            vectors++;
            if ({pe_en, loaded, ctrl_out} !== {2'b00, WORD_A}) begin
                miscompares++;
                $display("FAIL reload_nib%0d: en/ld=%b ctrl=%h expected 00 %h", k, {pe_en, loaded}, ctrl_out, WORD_A);
            end
        end
        send_nib(frame_b[7]);
        vectors++;
        if ({pe_en, loaded, ctrl_out} !== {2'b11, WORD_B}) begin
            miscompares++;
            $display("FAIL reload_commit: en/ld=%b ctrl=%h expected 11 %h", {pe_en, loaded}, ctrl_out, WORD_B);
        end
        tick();
        vectors++;
        if ({pe_en, loaded} !== 2'b01) begin
            miscompares++;
            $display("FAIL reload_commit_step_ignored: en/ld=%b expected 01", {pe_en, loaded});
        end
        tick();
        vectors++;
        if ({pe_en, loaded} !== 2'b11) begin
            miscompares++;
            $display("FAIL reload_held_step: en/ld=%b expected 11", {pe_en, loaded});
        end
        step = 1'b0;
        tick();
    endtask

    task automatic test_gaps();
        do_reset();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_nib(frame_a[k]);
            if (k < 7) begin
                for (int g = 0; g < 3; g++) begin
                    cfg_data = 4'hE;   // junk while cfg_valid is low
                    tick();
                    vectors++;
                    if ({cfg_ready, pe_en, loaded, ctrl_out} !== {3'b100, 32'h0}) begin
                        miscompares++;
                        $display("FAIL gap_k%0d_g%0d: rdy/en/ld=%b ctrl=%h expected 100 00000000",
                                 k, g, {cfg_ready, pe_en, loaded}, ctrl_out);
                    end
                end
            end
        end
        vectors++;
        if ({ctrl_out, pe_en, loaded, err} !== {WORD_A, 3'b110}) begin
            miscompares++;
            $display("FAIL gap_commit: ctrl=%h en/ld/err=%b expected %h 110", ctrl_out, {pe_en, loaded, err}, WORD_A);
        end
        tick();
    endtask

    task automatic test_restart();
        do_reset();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) send_nib(4'h9);
        // restart with a nibble presented in the same cycle: nibble is discarded
        cfg_start = 1'b1;
        send_nib(4'h7);
        cfg_start = 1'b0;
        vectors++;
        if ({cfg_ready, err, loaded, ctrl_out} !== {3'b110, 32'h0}) begin
            miscompares++;
            $display("FAIL restart_err: rdy/err/ld=%b ctrl=%h expected 110 00000000", {cfg_ready, err, loaded}, ctrl_out);
        end
        for (int k = 0; k < 7; k++) send_nib(frame_b[k]);
        // restart coinciding with the final handshake: no COMMIT
        cfg_start = 1'b1;
        send_nib(frame_b[7]);
        cfg_start = 1'b0;
        vectors++;
        if ({cfg_ready, pe_en, loaded, err, ctrl_out} !== {4'b1001, 32'h0}) begin
            miscompares++;
            $display("FAIL restart_on_last: rdy/en/ld/err=%b ctrl=%h expected 1001 00000000",
                     {cfg_ready, pe_en, loaded, err}, ctrl_out);
        end
        foreach (frame_b[k]) send_nib(frame_b[k]);
        vectors++;
        if ({ctrl_out, pe_en, loaded, err} !== {WORD_B, 3'b111}) begin
            miscompares++;
            $display("FAIL restart_commit: ctrl=%h en/ld/err=%b expected %h 111", ctrl_out, {pe_en, loaded, err}, WORD_B);
        end
        tick(); tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_mid_reset();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 5; k++) send_nib(frame_a[k]);
        do_reset();
        vectors++;
        if ({cfg_ready, pe_en, loaded, err, ctrl_out} !== {4'b0000, 32'h0}) begin
            miscompares++;
            $display("FAIL midreset: rdy/en/ld/err=%b ctrl=%h expected 0000 00000000",
                     {cfg_ready, pe_en, loaded, err}, ctrl_out);
        end
        for (int k = 0; k < 3; k++) send_nib(4'hB);
        vectors++;
        if ({cfg_ready, pe_en, loaded, ctrl_out} !== {3'b000, 32'h0}) begin
            miscompares++;
            $display("FAIL midreset_idle: rdy/en/ld=%b ctrl=%h expected 000 00000000",
                     {cfg_ready, pe_en, loaded}, ctrl_out);
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        foreach (frame_a[k]) send_nib(frame_a[k]);
        vectors++;
        if ({ctrl_out, pe_en, loaded, err} !== {WORD_A, 3'b110}) begin
            miscompares++;
            $display("FAIL midreset_reload: ctrl=%h en/ld/err=%b expected %h 110",
                     ctrl_out, {pe_en, loaded, err}, WORD_A);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_step();
        test_run_reload();
        test_gaps();
        test_restart();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
